// File: rtl/ascon_permutation_iter_pkg.sv
// Shared types, constants and helpers for the iterative Ascon permutation core.
// The state word order is x0 (MSB of the packed struct) through x4.
package ascon_pack;

    typedef struct packed {
        logic [63:0] x0;
        logic [63:0] x1;
        logic [63:0] x2;
        logic [63:0] x3;
        logic [63:0] x4;
    } type_state;

    typedef enum logic [1:0] {
        FSM_IDLE = 2'd0,
        FSM_RUN  = 2'd1,
        FSM_DONE = 2'd2
    } type_fsm;

    localparam logic [3:0] ROUND_LAST = 4'd11;
    localparam int         ROUNDS_MAX = 12;

    // Column value is {x0, x1, x2, x3, x4}.
    function automatic logic [4:0] sbox(input logic [4:0] x);
        logic [4:0] y;
        case (x)
            5'h00: y = 5'h04;  5'h01: y = 5'h0b;  5'h02: y = 5'h1f;  5'h03: y = 5'h14;
            5'h04: y = 5'h1a;  5'h05: y = 5'h15;  5'h06: y = 5'h09;  5'h07: y = 5'h02;
            5'h08: y = 5'h1b;  5'h09: y = 5'h05;  5'h0a: y = 5'h08;  5'h0b: y = 5'h12;
            5'h0c: y = 5'h1d;  5'h0d: y = 5'h03;  5'h0e: y = 5'h06;  5'h0f: y = 5'h1c;
            5'h10: y = 5'h1e;  5'h11: y = 5'h13;  5'h12: y = 5'h07;  5'h13: y = 5'h0e;
            5'h14: y = 5'h00;  5'h15: y = 5'h0d;  5'h16: y = 5'h11;  5'h17: y = 5'h18;
            5'h18: y = 5'h10;  5'h19: y = 5'h0c;  5'h1a: y = 5'h01;  5'h1b: y = 5'h19;
            5'h1c: y = 5'h16;  5'h1d: y = 5'h0a;  5'h1e: y = 5'h0f;  default: y = 5'h17;
        endcase
        return y;
    endfunction

    function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

endpackage

// File: rtl/ascon_permutation_iter_if.sv
// Request/result bundle between the permutation core and the mode datapath.
interface ascon_permutation_iter_if;
    import ascon_pack::*;

    logic      start_i;
    logic      mode_i;
    type_state state_i;
    type_state state_o;
    logic      busy_o;
    logic      done_o;

    modport master (
        output start_i, mode_i, state_i,
        input  state_o, busy_o, done_o
    );

    modport slave (
        input  start_i, mode_i, state_i,
        output state_o, busy_o, done_o
    );

endinterface

// File: rtl/ascon_permutation_iter_round.sv
// One combinational Ascon round: constant addition, S-box layer, linear layer.
module ascon_round
    import ascon_pack::*;
(
    input  type_state  state_cur,
    input  logic [3:0] round_idx,
    output type_state  state_nxt
);

    type_state s_c;
    type_state s_s;

    function automatic type_state sub_layer(input type_state s);
        type_state  r;
        logic [4:0] col;
        r = s;
        for (int b = 0; b < 64; b++) begin
            col = sbox({s.x0[b], s.x1[b], s.x2[b], s.x3[b], s.x4[b]});
            r.x0[b] = col[4];
            r.x1[b] = col[3];
            r.x2[b] = col[2];
            r.x3[b] = col[1];
            r.x4[b] = col[0];
        end
        return r;
    endfunction

    always_comb begin
        s_c    = state_cur;
        s_c.x2 = state_cur.x2 ^ {56'h0, 4'hF - round_idx, round_idx};
    end

    assign s_s = sub_layer(s_c);

    always_comb begin
        state_nxt    = s_s;
        state_nxt.x0 = s_s.x0 ^ ror64(s_s.x0, 19) ^ ror64(s_s.x0, 28);
        state_nxt.x1 = s_s.x1 ^ ror64(s_s.x1, 61) ^ ror64(s_s.x1, 39);
        state_nxt.x2 = s_s.x2 ^ ror64(s_s.x2, 1)  ^ ror64(s_s.x2, 6);
        state_nxt.x3 = s_s.x3 ^ ror64(s_s.x3, 10) ^ ror64(s_s.x3, 17);
        state_nxt.x4 = s_s.x4 ^ ror64(s_s.x4, 7)  ^ ror64(s_s.x4, 41);
    end

endmodule

// File: rtl/ascon_permutation_iter.sv
// Iterative Ascon p^a / p^b: one round per clock, result held until the next start.
//  state | meaning
//  IDLE  | waiting for start_i; state_o holds the last result
//  RUN   | applying one round per edge, counter 12-N .. 11
//  DONE  | single-cycle completion; start_i here reloads immediately
module ascon_permutation_iter
    import ascon_pack::*;
#(
    parameter int PA_ROUNDS = 12,
    parameter int PB_ROUNDS = 6
) (
    input  logic clock_i,
    input  logic reset_i,
    ascon_permutation_iter_if.slave bus
);

    localparam logic [1:0] IDLE = FSM_IDLE;
    localparam logic [1:0] RUN  = FSM_RUN;
    localparam logic [1:0] DONE = FSM_DONE;

    localparam logic [3:0] START_A = 4'(ROUNDS_MAX - PA_ROUNDS);
    localparam logic [3:0] START_B = 4'(ROUNDS_MAX - PB_ROUNDS);

    if (PA_ROUNDS < 1 || PA_ROUNDS > ROUNDS_MAX) begin : g_bad_pa
        $error("PA_ROUNDS must be in 1..12");
    end
    if (PB_ROUNDS < 1 || PB_ROUNDS > ROUNDS_MAX) begin : g_bad_pb
        $error("PB_ROUNDS must be in 1..12");
    end

    logic [1:0] fsm;
    logic [3:0] round_cnt;
    type_state  state_q;
    type_state  state_rnd;

    ascon_round u_round (
        .state_cur (state_q),
        .round_idx (round_cnt),
        .state_nxt (state_rnd)
    );

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            fsm       <= IDLE;
            round_cnt <= 4'd0;
            state_q   <= '0;
        end else begin
            case (fsm)
                IDLE, DONE: begin
                    if (bus.start_i) begin
                        state_q   <= bus.state_i;
                        round_cnt <= bus.mode_i ? START_B : START_A;
                        fsm       <= RUN;
                    end else begin
                        fsm <= IDLE;
                    end
                end
                RUN: begin
                    state_q <= state_rnd;
                    // Counter parks on the last index so it never passes 11.
                    if (round_cnt == ROUND_LAST) begin
                        fsm <= DONE;
                    end else begin
                        round_cnt <= round_cnt + 4'd1;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    assign bus.state_o = state_q;
    assign bus.busy_o  = (fsm == RUN);
    assign bus.done_o  = (fsm == DONE);

endmodule

// File: tb/tb_ascon_permutation_iter.sv
// Directed bench for ascon_permutation_iter with a bitsliced reference permutation.
module tb_ascon_permutation_iter;
    import ascon_pack::*;

    logic clock_i = 1'b0;
    logic reset_i;
    int   checks   = 0;
    int   failures = 0;

    always #5 clock_i = ~clock_i;

    ascon_permutation_iter_if ifa ();
    ascon_permutation_iter_if ifb ();

    ascon_permutation_iter u_dut_a (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .bus     (ifa.slave)
    );

    ascon_permutation_iter #(.PA_ROUNDS(12), .PB_ROUNDS(1)) u_dut_b (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .bus     (ifb.slave)
    );

    localparam type_state ZERO_ST = '0;
    localparam type_state IV_ST = {64'h80400c0600000000, 64'h0001020304050607,
                                   64'h08090a0b0c0d0e0f, 64'h0001020304050607,
                                   64'h08090a0b0c0d0e0f};

    task automatic check_val(input string tag, input logic [319:0] got, input logic [319:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // Bitsliced S-box formulation, independent of the table lookup.
    function automatic type_state m_round(input type_state s, input int r);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        x0 = s.x0; x1 = s.x1; x2 = s.x2; x3 = s.x3; x4 = s.x4;
        x2 ^= 64'(((15 - r) << 4) | r);
        x0 ^= x4; x4 ^= x3; x2 ^= x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
        x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
        x0 ^= rotr(x0, 19) ^ rotr(x0, 28);
        x1 ^= rotr(x1, 61) ^ rotr(x1, 39);
        x2 ^= rotr(x2, 1)  ^ rotr(x2, 6);
        x3 ^= rotr(x3, 10) ^ rotr(x3, 17);
        x4 ^= rotr(x4, 7)  ^ rotr(x4, 41);
        return type_state'({x0, x1, x2, x3, x4});
    endfunction

    function automatic type_state m_perm(input type_state s, input int first);
        type_state r = s;
        for (int i = first; i < 12; i++) r = m_round(r, i);
        return r;
    endfunction

    function automatic type_state rand_state();
        logic [319:0] v;
        for (int i = 0; i < 10; i++) v[i*32 +: 32] = $urandom;
        return type_state'(v);
    endfunction

    // Accepts on the next edge, then scrambles the don't-care inputs.
    task automatic run_a(input logic mode, input type_state s, output int lat, output int busy_cnt);
        ifa.start_i = 1'b1;
        ifa.mode_i  = mode;
        ifa.state_i = s;
        step();
        ifa.start_i = 1'b0;
        ifa.mode_i  = 1'($urandom);
        ifa.state_i = rand_state();
        lat      = 0;
        busy_cnt = ifa.busy_o ? 1 : 0;
        for (int e = 1; e <= 40; e++) begin
            step();
            if (ifa.done_o) begin
                lat = e;
                break;
            end
            if (ifa.busy_o) busy_cnt++;
        end
    endtask

    initial begin
        int        lat, bc, ndone, last_done, seen;
        type_state exp_st;

        reset_i     = 1'b1;
        ifa.start_i = 1'b0; ifa.mode_i = 1'b0; ifa.state_i = '0;
        ifb.start_i = 1'b0; ifb.mode_i = 1'b0; ifb.state_i = '0;
        repeat (3) @(posedge clock_i);
        #1;
        reset_i = 1'b0;
        step();
        check_val("rst_state", 320'(ifa.state_o), 320'(0));
        check_val("rst_busy",  320'(ifa.busy_o),  320'(0));
        check_val("rst_done",  320'(ifa.done_o),  320'(0));

        // Single round, index 11, all-zero input.
        ifb.start_i = 1'b1; ifb.mode_i = 1'b1; ifb.state_i = '0;
        step();
        ifb.start_i = 1'b0; ifb.state_i = rand_state();
        check_val("r1_busy", 320'(ifb.busy_o), 320'(1));
        check_val("r1_done_early", 320'(ifb.done_o), 320'(0));
        step();
        check_val("r1_done", 320'(ifb.done_o), 320'(1));
        check_val("r1_busy_off", 320'(ifb.busy_o), 320'(0));
        check_val("r1_x0", 320'(ifb.state_o.x0), 320'(64'h000964B00000004B));
        check_val("r1_x1", 320'(ifb.state_o.x1), 320'(64'h0000000096000213));
        check_val("r1_x2", 320'(ifb.state_o.x2), 320'(64'h53FFFFFFFFFFFF90));
        check_val("r1_x3", 320'(ifb.state_o.x3), 320'(64'h12E580000000004B));
        check_val("r1_x4", 320'(ifb.state_o.x4), 320'(0));
        step();
        check_val("r1_done_once", 320'(ifb.done_o), 320'(0));

        // p^a on zero state and on the Ascon-128 KAT 1 initial state.
        run_a(1'b0, ZERO_ST, lat, bc);
        check_val("pa0_lat",  320'(lat), 320'(12));
        check_val("pa0_busy", 320'(bc),  320'(12));
        check_val("pa0_state", 320'(ifa.state_o), 320'(m_perm(ZERO_ST, 0)));
        step();
        check_val("pa0_done_once", 320'(ifa.done_o), 320'(0));

        run_a(1'b0, IV_ST, lat, bc);
        check_val("paiv_lat",  320'(lat), 320'(12));
        check_val("paiv_busy", 320'(bc),  320'(12));
        check_val("paiv_state", 320'(ifa.state_o), 320'(m_perm(IV_ST, 0)));
        step();

        // p^b, rounds 6..11, then hold with noisy inputs.
        run_a(1'b1, IV_ST, lat, bc);
        exp_st = m_perm(IV_ST, 6);
        check_val("pb_lat",  320'(lat), 320'(6));
        check_val("pb_busy", 320'(bc),  320'(6));
        check_val("pb_state", 320'(ifa.state_o), 320'(exp_st));
        for (int i = 0; i < 20; i++) begin
            ifa.state_i = rand_state();
            ifa.mode_i  = 1'($urandom);
            step();
            check_val("hold_state", 320'(ifa.state_o), 320'(exp_st));
        end

        // start_i held high: reload on every DONE, one result every 7 edges.
        ifa.start_i = 1'b1; ifa.mode_i = 1'b1; ifa.state_i = IV_ST;
        ndone = 0; last_done = 0;
        for (int e = 1; e <= 28; e++) begin
            step();
            if (ifa.done_o) begin
                ndone++;
                check_val("b2b_gap", 320'(e - last_done), 320'(7));
                check_val("b2b_state", 320'(ifa.state_o), 320'(exp_st));
                last_done = e;
            end
        end
        ifa.start_i = 1'b0;
        check_val("b2b_count", 320'(ndone), 320'(4));
        step();

        // Asynchronous reset in the middle of a p^a run.
        ifa.start_i = 1'b1; ifa.mode_i = 1'b0; ifa.state_i = IV_ST;
        step();
        ifa.start_i = 1'b0;
        repeat (4) step();
        check_val("mid_busy", 320'(ifa.busy_o), 320'(1));
        #2;
        reset_i = 1'b1;
        #1;
        check_val("mid_rst_state", 320'(ifa.state_o), 320'(0));
        check_val("mid_rst_busy",  320'(ifa.busy_o),  320'(0));
        check_val("mid_rst_done",  320'(ifa.done_o),  320'(0));
        step();
        reset_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (ifa.done_o || ifa.busy_o) seen++;
        end
        check_val("mid_rst_no_done", 320'(seen), 320'(0));
        check_val("mid_rst_state_after", 320'(ifa.state_o), 320'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
